hs_ram_arbiter: RTL and testbench
=================================

# hs_ram_arbiter

Shares the game's work-RAM port between the running CPU and the hiscore save/restore engine. When the hiscore engine strobes a request, the block pauses the CPU and waits for it to halt. It then waits for the bus to settle, performs one RAM access on the engine's behalf and returns the result. It keeps the CPU paused briefly so burst transfers avoid repeated halt overhead. Sits between the hiscore engine, the pause logic and the core's RAM address/data mux, all on clk_49m.

## Interface
Parameters:
- AW, 12, RAM address width
- DW, 8, RAM data width
- SETTLE, 4, cycles waited after CPU halt before first access (≥1)
- RD_LAT, 1, RAM read latency in cycles (≥1)
- HOLD_CYC, 16, idle cycles in HOLD before the pause is released (≥1)
- WDOG, 1024, halt-wait timeout in cycles (used only with the watchdog macro)

Ports:
- clk_49m  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  AW  CPU address
- cpu_dout  in  DW  CPU write data
- cpu_cs  in  1  CPU RAM select
- cpu_we  in  1  CPU write
- cpu_halted  in  1  CPU stopped at an instruction boundary
- pause_cpu  out  1  pause request to the CPU
- ram_addr  out  AW  muxed RAM address
- ram_din  out  DW  muxed RAM write data
- ram_we  out  1  muxed RAM write enable
- ram_dout  in  DW  RAM read data
- hs_req  in  1  one-cycle request strobe
- hs_we  in  1  request is a write (sampled with hs_req)
- hs_addr  in  AW  request address (sampled with hs_req)
- hs_din  in  DW  request write data (sampled with hs_req)
- hs_ack  out  1  one-cycle completion strobe
- hs_dout  out  DW  read result, valid with hs_ack and held afterwards
- busy  out  1  state ≠ IDLE
- wdog_err  out  1  sticky halt timeout (present only with the watchdog macro)

## Operation
- Request latch: on hs_req, register hs_addr, hs_din and hs_we.
  - At most one request may be outstanding.
  - hs_req outside IDLE or HOLD is ignored.
- Mux:
  - grant=0: ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=cpu_cs&cpu_we.
  - grant=1: latched address and data drive the RAM. ram_we is high only in ACCESS, and only for a write.
- States:
  - IDLE: pause_cpu=0, grant=0. hs_req → HALT_WAIT.
  - HALT_WAIT: pause_cpu=1. cpu_halted → SETTLE with counter=SETTLE-1.
  - SETTLE: count down; at 0 → ACCESS.
  - ACCESS: grant=1 for one cycle → DATA with counter=RD_LAT-1.
  - DATA: grant=1; at 0 → capture ram_dout into hs_dout, pulse hs_ack on the next cycle, → HOLD with counter=HOLD_CYC-1.
  - HOLD: pause_cpu=1, grant=0.
    - hs_req → ACCESS; no halt wait or settle is repeated.
    - Counter reaching 0 with no request → IDLE.
    - hs_req in the same cycle as expiry wins; go to ACCESS.
- Write requests still pass through DATA. hs_dout then holds the RAM data at the written address.
- cpu_halted dropping in SETTLE, ACCESS, DATA or HOLD is a protocol error; the block ignores it.
- A single counter serves SETTLE, DATA, HOLD and the watchdog.

## Timing
- Reset values:
  - state=IDLE, pause_cpu=0, grant=0, ram_we follows the CPU path, hs_ack=0, hs_dout=0, busy=0, wdog_err=0.
  - Reset mid-operation releases the pause in the next cycle. No hs_ack is issued for the aborted request.
- First access, with cpu_halted already high:
  - hs_req at cycle 0 → pause_cpu high from cycle 1 → ACCESS at cycle 2+SETTLE → hs_ack at cycle 3+SETTLE+RD_LAT.
  - With defaults: ACCESS at cycle 6, hs_ack at cycle 8.
- From HOLD: hs_req at cycle h → ACCESS at h+1 → hs_ack at h+2+RD_LAT.
- Pause release: pause_cpu falls HOLD_CYC+1 cycles after the last hs_ack if no new request arrives.

## Configuration
- HS_ARB_WATCHDOG_EN defined:
  - HALT_WAIT counts up to WDOG cycles.
  - On expiry: set wdog_err (sticky until reset), pulse hs_ack with hs_dout=0, release the pause, → IDLE.
- HS_ARB_WATCHDOG_EN undefined:
  - HALT_WAIT waits indefinitely.
  - The wdog_err port and the WDOG logic are absent.

## Structure
- Package hs_arb_pkg holds:
  - the state enum (IDLE, HALT_WAIT, SETTLE, ACCESS, DATA, HOLD);
  - default parameter constants;
  - the counter width, derived as $clog2 of max(SETTLE, RD_LAT, HOLD_CYC, WDOG).
- No sub-module: a single FSM plus one shared counter is the natural structure.

## Test plan
- Read from IDLE, defaults, cpu_halted=1, hs_addr=0x123, RAM model holds 0xA5: pause_cpu rises at cycle 1, ram_addr=0x123 at cycle 6, hs_ack with hs_dout=0xA5 at cycle 8.
- Write, hs_we=1, hs_addr=0x040, hs_din=0x3C: ram_we high for exactly one cycle with ram_addr=0x040 and ram_din=0x3C; RAM reads back 0x3C.
- Burst of 4 reads, each issued 2 cycles after the previous hs_ack: only the first request waits for halt and settle; acks are spaced by RD_LAT+4; pause_cpu drops 17 cycles after the last ack.
- cpu_halted delayed 50 cycles: state stays HALT_WAIT and the CPU path drives the RAM throughout; the access happens 4 cycles after halt.
- Reset asserted during DATA: the next cycle shows pause_cpu=0, busy=0, no hs_ack, and the CPU path restored.
- With HS_ARB_WATCHDOG_EN and cpu_halted held at 0: at cycle 1+1024, hs_ack pulses with hs_dout=0, wdog_err=1 and stays high, pause_cpu=0.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg
// Shared definitions for the hiscore RAM arbiter:
//   - default values for every hs_ram_arbiter parameter
//   - the arbiter state encoding
//   - cnt_width(): width of the single shared SETTLE/DATA/HOLD/watchdog counter,
//     derived as $clog2 of the largest count it must hold.
package hs_arb_pkg;

  localparam int DEF_AW       = 12;
  localparam int DEF_DW       = 8;
  localparam int DEF_SETTLE   = 4;
  localparam int DEF_RD_LAT   = 1;
  localparam int DEF_HOLD_CYC = 16;
  localparam int DEF_WDOG     = 1024;

  // The ST_ prefix keeps the SETTLE state clear of the SETTLE parameter
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_SETTLE,
    ST_ACCESS,
    ST_DATA,
    ST_HOLD
  } arb_state_t;

  // Every count loaded is at most (limit - 1), so $clog2(limit) bits suffice.
  // The floor of 2 keeps the counter at least one bit wide.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

  localparam int DEF_CW = cnt_width(DEF_SETTLE, DEF_RD_LAT, DEF_HOLD_CYC, DEF_WDOG);

endpackage

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
// Shares the work-RAM port between the CPU and the hiscore save/restore engine.
// A request pauses the CPU, waits for it to halt, lets the bus settle, performs
// one RAM access for the engine and returns the result. The CPU stays paused
// for a while afterwards so bursts skip the halt/settle overhead.
//
// Optional feature: define HS_ARB_WATCHDOG_EN to add a halt-wait timeout that
// raises the sticky wdog_err output and completes the request with data 0.
//
// Ports:
//   clk_49m, reset          clock, synchronous active-high reset
//   cpu_addr/dout/cs/we     CPU side of the RAM mux
//   cpu_halted              CPU has stopped at an instruction boundary
//   pause_cpu               pause request to the CPU
//   ram_addr/din/we         muxed RAM port, ram_dout is the RAM read data
//   hs_req/we/addr/din      one-cycle request strobe with its payload
//   hs_ack, hs_dout         one-cycle completion strobe, held read result
//   busy                    arbiter not idle
//   wdog_err                sticky halt timeout (HS_ARB_WATCHDOG_EN only)
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int WDOG     = DEF_WDOG
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic          cpu_halted,
  output logic          pause_cpu,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_din,
  output logic          hs_ack,
  output logic [DW-1:0] hs_dout,
  output logic          busy
`ifdef HS_ARB_WATCHDOG_EN
  ,
  output logic          wdog_err
`endif
);

  localparam int CW = cnt_width(SETTLE, RD_LAT, HOLD_CYC, WDOG);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          capture;
  logic          wdog_fire;
  logic          grant;
  logic          req_accept;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_din;
  logic          req_we;

  // A new request is only taken when no access is in flight
  assign req_accept = hs_req && ((state == ST_IDLE) || (state == ST_HOLD));

  assign pause_cpu = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign grant     = (state == ST_ACCESS) || (state == ST_DATA);

  // RAM port mux: the engine owns the bus only in ACCESS and DATA, and only
  // the ACCESS cycle may write.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_cs & cpu_we;
    if (grant) begin
      ram_addr = req_addr;
      ram_din  = req_din;
      ram_we   = (state == ST_ACCESS) && req_we;
    end
  end

  // Next-state logic. One counter is reused: settle delay, read latency,
  // HOLD timeout and (optionally) the halt-wait watchdog counting upwards.
  // A cpu_halted drop after HALT_WAIT is deliberately not looked at.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    wdog_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs_req) begin
          state_nxt = ST_HALT_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_HALT_WAIT: begin
        if (cpu_halted) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CW'(SETTLE - 1);
        end
`ifdef HS_ARB_WATCHDOG_EN
        else if (cnt == CW'(WDOG - 1)) begin
          state_nxt = ST_IDLE;
          wdog_fire = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_ACCESS;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_DATA;
        cnt_nxt   = CW'(RD_LAT - 1);
      end
      ST_DATA: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CW'(HOLD_CYC - 1);
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        // A request always beats expiry. The ack cycle is not an idle cycle,
        // so the HOLD timeout only starts counting once hs_ack has dropped.
        if (hs_req) begin
          state_nxt = ST_ACCESS;
        end else if (!hs_ack) begin
          if (cnt == '0) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter, request latch and result registers
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hs_ack   <= 1'b0;
      hs_dout  <= '0;
      req_addr <= '0;
      req_din  <= '0;
      req_we   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hs_ack <= capture | wdog_fire;
      if (capture) begin
        hs_dout <= ram_dout;
      end else if (wdog_fire) begin
        hs_dout <= '0;
      end
      if (req_accept) begin
        req_addr <= hs_addr;
        req_din  <= hs_din;
        req_we   <= hs_we;
      end
    end
  end

`ifdef HS_ARB_WATCHDOG_EN
  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      wdog_err <= 1'b0;
    end else if (wdog_fire) begin
      wdog_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter
// Self-checking bench for hs_ram_arbiter with default parameters.
// A cycle-by-cycle vector table covers a read from IDLE and a write plus
// readback from HOLD; hand-written sequences cover the HOLD release, a burst,
// a late halt, reset during DATA and (with HS_ARB_WATCHDOG_EN) the watchdog.
module tb_hs_ram_arbiter;

  logic        clk_49m;
  logic        reset;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_cs;
  logic        cpu_we;
  logic        cpu_halted;
  logic        pause_cpu;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        hs_req;
  logic        hs_we;
  logic [11:0] hs_addr;
  logic [7:0]  hs_din;
  logic        hs_ack;
  logic [7:0]  hs_dout;
  logic        busy;
`ifdef HS_ARB_WATCHDOG_EN
  logic        wdog_err;
`endif

  int n_vec;
  int n_miss;

  hs_ram_arbiter dut (
    .clk_49m   (clk_49m),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_halted(cpu_halted),
    .pause_cpu (pause_cpu),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .hs_req    (hs_req),
    .hs_we     (hs_we),
    .hs_addr   (hs_addr),
    .hs_din    (hs_din),
    .hs_ack    (hs_ack),
    .hs_dout   (hs_dout),
    .busy      (busy)
`ifdef HS_ARB_WATCHDOG_EN
    ,
    .wdog_err  (wdog_err)
`endif
  );

  initial clk_49m = 1'b0;
  always #5 clk_49m = ~clk_49m;

  // Background contents of the RAM model
  function automatic logic [7:0] pattern(input logic [11:0] a);
    if (a == 12'h123) return 8'hA5;
    return a[7:0] ^ 8'h5A;
  endfunction

  // Synchronous RAM model, one cycle read latency, write-through on writes
  bit [7:0] wmem [4096];
  bit       wflag[4096];
  always @(posedge clk_49m) begin
    if (ram_we) begin
      wmem[ram_addr]  <= ram_din;
      wflag[ram_addr] <= 1'b1;
      ram_dout        <= ram_din;
    end else begin
      ram_dout <= wflag[ram_addr] ? wmem[ram_addr] : pattern(ram_addr);
    end
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  din;
    logic        cwe;
    logic        e_pause;
    logic        e_busy;
    logic        e_ack;
    logic        e_we;
    logic [11:0] e_addr;
    logic [7:0]  e_din;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic req, input logic we, input logic [11:0] a,
                              input logic [7:0] d, input logic cwe, input logic ep,
                              input logic eb, input logic ea, input logic ewe,
                              input logic [11:0] eaddr, input logic [7:0] edin,
                              input logic [7:0] edout);
    vec_t v;
    v.req = req; v.we = we; v.addr = a; v.din = d; v.cwe = cwe;
    v.e_pause = ep; v.e_busy = eb; v.e_ack = ea; v.e_we = ewe;
    v.e_addr = eaddr; v.e_din = edin; v.e_dout = edout;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    tick();
    hs_req  = v.req;
    hs_we   = v.we;
    hs_addr = v.addr;
    hs_din  = v.din;
    cpu_we  = v.cwe;
  endtask

  task automatic req_cycle(input logic we, input logic [11:0] a, input logic [7:0] d);
    tick();
    hs_req = 1'b1; hs_we = we; hs_addr = a; hs_din = d;
    @(negedge clk_49m);
  endtask

  task automatic idle_cycle();
    tick();
    hs_req = 1'b0;
    @(negedge clk_49m);
  endtask

  // Cycles from the request cycle to the ack cycle (limit+1 on timeout)
  task automatic wait_ack(input int limit, output int n);
    n = 0;
    do begin
      idle_cycle();
      n++;
    end while (!hs_ack && n <= limit);
  endtask

  // Cycles from the current cycle until pause_cpu reads low (limit+1 on timeout)
  task automatic wait_release(input int limit, output int n);
    n = 0;
    do begin
      idle_cycle();
      n++;
    end while (pause_cpu && n <= limit);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    int bad;
    n_vec  = 0;
    n_miss = 0;
    reset = 1'b1;
    cpu_addr = 12'hABC; cpu_dout = 8'h11; cpu_cs = 1'b1; cpu_we = 1'b0;
    cpu_halted = 1'b1;
    hs_req = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_din = '0;

    //                req we  addr     din    cwe p  b  ack we  e_addr   e_din  e_dout
    tbl[0]  = mk(1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 0, 0, 0, 0, 12'hABC, 8'h11, 8'h00);
    tbl[1]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'hABC, 8'h11, 8'h00);
    tbl[2]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'hABC, 8'h11, 8'h00);
    tbl[3]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1, 1, 0, 1, 12'hABC, 8'h11, 8'h00);
    tbl[4]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'hABC, 8'h11, 8'h00);
    tbl[5]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'hABC, 8'h11, 8'h00);
    tbl[6]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'h123, 8'h00, 8'h00);
    tbl[7]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'h123, 8'h00, 8'h00);
    tbl[8]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 1, 0, 12'hABC, 8'h11, 8'hA5);
    tbl[9]  = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'hABC, 8'h11, 8'hA5);
    tbl[10] = mk(1'b1, 1'b1, 12'h040, 8'h3C, 1'b0, 1, 1, 0, 0, 12'hABC, 8'h11, 8'hA5);
    tbl[11] = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 1, 12'h040, 8'h3C, 8'hA5);
    tbl[12] = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'h040, 8'h3C, 8'hA5);
    tbl[13] = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 1, 0, 12'hABC, 8'h11, 8'h3C);
    tbl[14] = mk(1'b1, 1'b0, 12'h040, 8'h00, 1'b0, 1, 1, 0, 0, 12'hABC, 8'h11, 8'h3C);
    tbl[15] = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'h040, 8'h00, 8'h3C);
    tbl[16] = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 0, 0, 12'h040, 8'h00, 8'h3C);
    tbl[17] = mk(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1, 1, 1, 0, 12'hABC, 8'h11, 8'h3C);

    tick();
    tick();
    // The first table row releases reset; reset was sampled at the edge before it
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i]);
      if (i == 0) reset = 1'b0;
      @(negedge clk_49m);
      checkOutput($sformatf("v%0d.pause", i), int'(pause_cpu), int'(tbl[i].e_pause));
      checkOutput($sformatf("v%0d.busy", i), int'(busy), int'(tbl[i].e_busy));
      checkOutput($sformatf("v%0d.ack", i), int'(hs_ack), int'(tbl[i].e_ack));
      checkOutput($sformatf("v%0d.ram_we", i), int'(ram_we), int'(tbl[i].e_we));
      checkOutput($sformatf("v%0d.ram_addr", i), int'(ram_addr), int'(tbl[i].e_addr));
      checkOutput($sformatf("v%0d.ram_din", i), int'(ram_din), int'(tbl[i].e_din));
      checkOutput($sformatf("v%0d.hs_dout", i), int'(hs_dout), int'(tbl[i].e_dout));
    end
    cpu_we = 1'b0;

    // Release of the pause after the last ack of the table
    wait_release(40, n);
    checkOutput("release_after_table", n, 17);

    // Burst of four reads: only the first one pays halt + settle
    $display("[TB] burst of four reads");
    req_cycle(1'b0, 12'h200, 8'h00);
    wait_ack(20, n);
    checkOutput("burst0.latency", n, 8);
    checkOutput("burst0.dout", int'(hs_dout), int'(pattern(12'h200)));
    for (int k = 1; k < 4; k++) begin
      idle_cycle();
      req_cycle(1'b0, 12'h200 + 12'(k), 8'h00);
      wait_ack(20, n);
      checkOutput($sformatf("burst%0d.ack_spacing", k), n + 2, 5);
      checkOutput($sformatf("burst%0d.dout", k), int'(hs_dout), int'(pattern(12'h200 + 12'(k))));
    end
    wait_release(40, n);
    checkOutput("burst.release", n, 17);
    checkOutput("burst.idle_busy", int'(busy), 0);

`ifdef HS_ARB_WATCHDOG_EN
    // Halt never comes: the watchdog completes the request with data 0
    $display("[TB] watchdog timeout");
    cpu_halted = 1'b0;
    req_cycle(1'b0, 12'h0AC, 8'h00);
    wait_ack(1100, n);
    checkOutput("wdog.latency", n, 1025);
    checkOutput("wdog.dout", int'(hs_dout), 0);
    checkOutput("wdog.err", int'(wdog_err), 1);
    checkOutput("wdog.pause", int'(pause_cpu), 0);
    for (int k = 0; k < 3; k++) idle_cycle();
    checkOutput("wdog.err_sticky", int'(wdog_err), 1);
    checkOutput("wdog.busy", int'(busy), 0);
`endif

    // Late halt: the CPU keeps the RAM for the whole wait
    $display("[TB] late cpu_halted");
    cpu_halted = 1'b0;
    req_cycle(1'b0, 12'h0AA, 8'h00);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      hs_req   = 1'b0;
      cpu_addr = 12'h300 + 12'(i);
      @(negedge clk_49m);
      if (!busy || !pause_cpu || ram_addr != cpu_addr || hs_ack) bad++;
    end
    checkOutput("late_halt.cpu_path_cycles_bad", bad, 0);
    tick();
    cpu_halted = 1'b1;
    cpu_addr   = 12'hABC;
    @(negedge clk_49m);
    n = 0;
    do begin
      idle_cycle();
      n++;
    end while (ram_addr != 12'h0AA && n <= 20);
    checkOutput("late_halt.access_delay", n, 5);
    wait_ack(10, n);
    checkOutput("late_halt.ack_after_access", n, 2);
    checkOutput("late_halt.dout", int'(hs_dout), int'(pattern(12'h0AA)));

    // Reset while in DATA: pause dropped next cycle, no ack, CPU path back
    $display("[TB] reset during DATA");
    req_cycle(1'b0, 12'h0AB, 8'h00);
    idle_cycle();
    tick();
    reset = 1'b1;
    @(negedge clk_49m);
    checkOutput("rst.in_data_grant", int'(ram_addr), 12'h0AB);
    tick();
    reset = 1'b0;
    @(negedge clk_49m);
    checkOutput("rst.pause", int'(pause_cpu), 0);
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.ack", int'(hs_ack), 0);
    checkOutput("rst.ram_addr", int'(ram_addr), 12'hABC);
    checkOutput("rst.hs_dout", int'(hs_dout), 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      if (hs_ack || busy) bad++;
    end
    checkOutput("rst.no_late_ack", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
